// File: rtl/frogger_engine_if.sv
// Pin bundle for frogger_engine: control strobes in, pixel maps and game status out.
interface frogger_engine_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  // Strobes are single-cycle pulses with no back-pressure: each one is consumed on the edge that sees it.
  logic                      move_l;
  logic                      move_r;
  logic                      move_u;
  logic                      move_d;
  logic                      tick;
  logic [ROWS-1:0][COLS-1:0] red_pixels;
  logic [ROWS-1:0][COLS-1:0] grn_pixels;
  logic [7:0]                score;
  logic [3:0]                lives;
  logic                      crash_pulse;
  logic                      win_pulse;
  logic                      game_over;
  logic [1:0]                state_dbg;

  modport master (
    output move_l, move_r, move_u, move_d, tick,
    input  red_pixels, grn_pixels, score, lives, crash_pulse, win_pulse, game_over, state_dbg
  );

  modport slave (
    input  move_l, move_r, move_u, move_d, tick,
    output red_pixels, grn_pixels, score, lives, crash_pulse, win_pulse, game_over, state_dbg
  );
endinterface

// File: rtl/frogger_engine.sv
// Frogger game engine: frog/lane state machine driving the red (car) and green (frog) maps.
// Define FROGGER_LFSR_EN to feed the lanes from a 16-bit LFSR instead of circular rotation.
module frogger_engine #(
  parameter int              ROWS         = 16,
  parameter int              COLS         = 16,
  parameter int              LIVES        = 3,
  parameter int              HIT_CYCLES   = 8,
  parameter logic [COLS-1:0] INIT_PATTERN = 16'h0F0F
) (
  input logic             clk,
  input logic             reset,
  frogger_engine_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int HW = $clog2(HIT_CYCLES);
  localparam logic [CW-1:0] START_COL = CW'(COLS / 2);
  localparam logic [RW-1:0] GOAL_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Lane row r starts as INIT_PATTERN rotated left by r; start and goal rows stay empty.
  function automatic logic [ROWS-1:0][COLS-1:0] init_lanes();
    logic [ROWS-1:0][COLS-1:0] g;
    logic [COLS-1:0]           p;
    g = '0;
    p = INIT_PATTERN;
    for (int r = 1; r < ROWS - 1; r++) begin
      p = {p[COLS-2:0], p[COLS-1]};
      g[r] = p;
    end
    return g;
  endfunction

  localparam logic [ROWS-1:0][COLS-1:0] LANES_INIT = init_lanes();

  state_t                    state;
  logic [RW-1:0]             frow;
  logic [CW-1:0]             fcol;
  logic [ROWS-1:0][COLS-1:0] lanes;
  logic [ROWS-1:0][COLS-1:0] lanes_shifted;
  logic [7:0]                score;
  logic [3:0]                lives;
  logic [HW-1:0]             hit_cnt;
  logic                      crash_pulse;
  logic                      win_pulse;
  logic                      collide;
  logic                      goal;
  logic                      one_move;

`ifdef FROGGER_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (bus.tick) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

  // Odd lanes drift toward col 0, even lanes toward col COLS-1; fill uses pre-tick values.
  always_comb begin
    logic fill;
    lanes_shifted = '0;
    fill          = 1'b0;
    for (int r = 1; r < ROWS - 1; r++) begin
`ifdef FROGGER_LFSR_EN
      fill = lfsr[r % 16] & lfsr[(r + 5) % 16];
`else
      fill = (r % 2 == 1) ? lanes[r][0] : lanes[r][COLS-1];
`endif
      if (r % 2 == 1) lanes_shifted[r] = {fill, lanes[r][COLS-1:1]};
      else            lanes_shifted[r] = {lanes[r][COLS-2:0], fill};
    end
  end

  assign collide  = (state == PLAY) && lanes[frow][fcol];
  assign goal     = (state == PLAY) && (frow == GOAL_ROW);
  assign one_move = $onehot({bus.move_l, bus.move_r, bus.move_u, bus.move_d});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      frow        <= '0;
      fcol        <= START_COL;
      lanes       <= LANES_INIT;
      score       <= '0;
      lives       <= 4'(LIVES);
      hit_cnt     <= '0;
      crash_pulse <= 1'b0;
      win_pulse   <= 1'b0;
    end else begin
      crash_pulse <= 1'b0;
      win_pulse   <= 1'b0;
      if (bus.tick) lanes <= lanes_shifted;
      case (state)
        PLAY: begin
          // A crash outranks a goal and any move seen in the same cycle.
          if (collide) begin
            state       <= HIT;
            crash_pulse <= 1'b1;
            lives       <= lives - 4'd1;
            hit_cnt     <= '0;
          end else if (goal) begin
            win_pulse <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            frow <= '0;
            fcol <= START_COL;
          end else if (one_move) begin
            if (bus.move_u && frow != GOAL_ROW) frow <= frow + 1'b1;
            if (bus.move_d && frow != '0)       frow <= frow - 1'b1;
            if (bus.move_r && fcol != LAST_COL) fcol <= fcol + 1'b1;
            if (bus.move_l && fcol != '0)       fcol <= fcol - 1'b1;
          end
        end
        HIT: begin
          if (hit_cnt == HW'(HIT_CYCLES - 1)) begin
            hit_cnt <= '0;
            frow    <= '0;
            fcol    <= START_COL;
            state   <= (lives == 4'd0) ? OVER : PLAY;
          end else begin
            hit_cnt <= hit_cnt + 1'b1;
          end
        end
        OVER:    state <= OVER;
        default: state <= PLAY;
      endcase
    end
  end

  always_comb begin
    bus.red_pixels = lanes;
    bus.grn_pixels = '0;
    case (state)
      PLAY:    bus.grn_pixels[frow][fcol] = 1'b1;
      HIT:     bus.grn_pixels[frow][fcol] = hit_cnt[0];
      OVER:    bus.red_pixels = '1;
      default: bus.grn_pixels = '0;
    endcase
  end

  assign bus.score       = score;
  assign bus.lives       = lives;
  assign bus.crash_pulse = crash_pulse;
  assign bus.win_pulse   = win_pulse;
  assign bus.game_over   = (state == OVER);
  assign bus.state_dbg   = state;
endmodule

// File: doc/frogger_engine.md
FROGGER_ENGINE -- requirements
Module: frogger_engine

Interface
REQ-001 Parameter ROWS, 16, grid rows (>=4); row 0 is the start row and row ROWS-1 is the goal row.
REQ-002 Parameter COLS, 16, grid columns (>=4).
REQ-003 Parameter LIVES, 3, lives loaded at reset (1..15).
REQ-004 Parameter HIT_CYCLES, 8, length of the HIT state in clk cycles (>=2).
REQ-005 Parameter INIT_PATTERN, 16'h0F0F, COLS-bit seed for the lane contents.
REQ-006 clk  in  1  system clock; every register is clocked on posedge clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 move_l, move_r, move_u, move_d  in  1 each  single-cycle move pulses (debounced upstream).
REQ-009 tick  in  1  single-cycle lane-advance strobe.
REQ-010 red_pixels  out  [ROWS-1:0][COLS-1:0]  car map, indexed [row][col].
REQ-011 grn_pixels  out  [ROWS-1:0][COLS-1:0]  frog map, indexed [row][col].
REQ-012 score  out  8  goal count; saturates at 255.
REQ-013 lives  out  4  remaining lives.
REQ-014 crash_pulse, win_pulse  out  1 each  one-cycle event strobes.
REQ-015 game_over  out  1  high while in state OVER.

Function
REQ-016 FSM states: PLAY, HIT, OVER; reset state is PLAY.
REQ-017 Frog position is (frow, fcol); start position is (0, COLS/2).
REQ-018 In PLAY, exactly one asserted move pulse moves the frog one cell on the next edge; more than one asserted pulse in the same cycle is ignored.
REQ-019 A move that would leave the grid is ignored and the position holds; moves are ignored in HIT and OVER.
REQ-020 Lane rows are 1..ROWS-2; rows 0 and ROWS-1 are always 0 in red_pixels.
REQ-021 On tick, odd lane rows shift toward col 0: col c takes col c+1, and col COLS-1 takes the fill bit. Even lane rows shift toward col COLS-1, and col 0 takes the fill bit.
REQ-022 Lanes advance on tick in every state, including HIT and OVER.
REQ-023 Collision condition: red_pixels[frow][fcol]==1 while in PLAY, evaluated on the registered position and lane values.
REQ-024 On a collision, the FSM enters HIT on the next edge with crash_pulse=1 for one cycle and lives decremented by 1.
REQ-025 HIT lasts HIT_CYCLES cycles; grn shows the frog pixel only on odd hit-counter values (blink).
REQ-026 On HIT exit: if lives==0, go to OVER; otherwise go to PLAY with the frog at the start position.
REQ-027 When frow reaches ROWS-1 in PLAY, the next edge sets win_pulse=1 for one cycle, increments score (saturating), and returns the frog to the start position.
REQ-028 If a goal and a collision coincide in the same cycle, the collision wins and score is unchanged.
REQ-029 In OVER, grn_pixels is all 0 and red_pixels is all 1; only reset exits OVER.
REQ-030 In PLAY, grn_pixels is one-hot at (frow, fcol).
REQ-031 All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.

Reset
REQ-032 Reset sets: state=PLAY, frog=(0, COLS/2), score=0, lives=LIVES, pulses=0, hit counter=0.
REQ-033 Reset loads each lane row r with INIT_PATTERN rotated left by r; the LFSR is set to 16'hACE1.
REQ-034 Reset asserted mid-HIT or mid-OVER takes effect asynchronously, with no pending pulse emitted after release.

Configuration
REQ-035 With macro FROGGER_LFSR_EN defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances on each tick; the fill bit for lane r is lfsr[r%16] & lfsr[(r+5)%16].
REQ-036 With FROGGER_LFSR_EN undefined, there is no LFSR and each lane rotates circularly: the fill bit is the bit shifted out of the same row.

Verification (defaults; FROGGER_LFSR_EN undefined unless stated)
REQ-037 Reset, then 3 move_u pulses with no tick -> frog at (3,8); grn_pixels[3][8]=1; lives=3.
REQ-038 Reset, then move_l and move_u pulsed in the same cycle -> position stays (0,8).
REQ-039 From start, one move_d pulse -> position stays (0,8). Eight move_r pulses -> fcol saturates at 15.
REQ-040 Move the frog onto a cell where red=1 -> crash_pulse for 1 cycle, lives=2, 8 HIT cycles, frog back at (0,8).
REQ-041 Three successive crashes -> lives=0, game_over=1, red all 1s; further moves are ignored; reset clears game_over.
REQ-042 With FROGGER_LFSR_EN defined and 16 ticks after reset, the lane contents match the reference LFSR model bit-exactly; a goal reached on the same cycle as a crash yields score unchanged.
